// File: rtl/restoring_divider_pl.sv
// restoring_divider_pl: radix-2 restoring divider, one quotient bit per clock, valid/ready on both sides.
// Optional DIV_SIGNED_EN macro selects two's-complement operands (truncating division); default is unsigned.
module restoring_divider_pl #(
   parameter int DIVIDEND_W = 16,
   parameter int DIVISOR_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero
);
   localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DIVIDEND_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic [CW-1:0]           count_r;
   // Dividend bits shift out of the top while quotient bits shift in at the bottom.
   logic [DIVIDEND_W-1:0]   acc_r;
   logic [DIVISOR_W-1:0]    part_r;
   logic [DIVISOR_W-1:0]    dsr_r;
   logic                    in_ready_r;
   logic                    out_valid_r;
   logic [DIVIDEND_W-1:0]   quotient_r;
   logic [DIVISOR_W-1:0]    remainder_r;
   logic                    dbz_r;

   logic [DIVISOR_W:0]      trial_s;
   logic                    qbit_s;
   logic [DIVISOR_W-1:0]    part_next_s;
   logic [DIVIDEND_W-1:0]   acc_next_s;
   logic [DIVIDEND_W-1:0]   q_final_s;
   logic [DIVISOR_W-1:0]    r_final_s;
   logic [DIVIDEND_W-1:0]   dvd_mag_s;
   logic [DIVISOR_W-1:0]    dsr_mag_s;

`ifdef DIV_SIGNED_EN
   logic                    neg_q_r;
   logic                    neg_r_r;

   function automatic logic [DIVIDEND_W-1:0] abs_dvd(input logic [DIVIDEND_W-1:0] v);
      abs_dvd = v[DIVIDEND_W-1] ? (DIVIDEND_W'(0) - v) : v;
   endfunction

   function automatic logic [DIVISOR_W-1:0] abs_dsr(input logic [DIVISOR_W-1:0] v);
      abs_dsr = v[DIVISOR_W-1] ? (DIVISOR_W'(0) - v) : v;
   endfunction
`endif

   // Operand magnitudes captured at the accepting edge.
   always_comb begin
`ifdef DIV_SIGNED_EN
      dvd_mag_s = abs_dvd(dividend);
      dsr_mag_s = abs_dsr(divisor);
`else
      dvd_mag_s = dividend;
      dsr_mag_s = divisor;
`endif
   end

   // One restoring step plus the result fix-up used on the final RUN edge.
   always_comb begin
      trial_s = {part_r, acc_r[DIVIDEND_W-1]};
      if (trial_s >= {1'b0, dsr_r}) begin
         qbit_s      = 1'b1;
         part_next_s = DIVISOR_W'(trial_s - {1'b0, dsr_r});
      end else begin
         qbit_s      = 1'b0;
         part_next_s = trial_s[DIVISOR_W-1:0];
      end
      acc_next_s = {acc_r[DIVIDEND_W-2:0], qbit_s};
`ifdef DIV_SIGNED_EN
      // Negating the magnitude of most-negative / -1 wraps back to most-negative.
      if (neg_q_r) begin
         q_final_s = DIVIDEND_W'(0) - acc_next_s;
      end else begin
         q_final_s = acc_next_s;
      end
      if (neg_r_r) begin
         r_final_s = DIVISOR_W'(0) - part_next_s;
      end else begin
         r_final_s = part_next_s;
      end
`else
      q_final_s = acc_next_s;
      r_final_s = part_next_s;
`endif
   end

   // Control FSM: operand capture, iterative division, result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         count_r     <= '0;
         acc_r       <= '0;
         part_r      <= '0;
         dsr_r       <= '0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         dbz_r       <= 1'b0;
`ifdef DIV_SIGNED_EN
         neg_q_r     <= 1'b0;
         neg_r_r     <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  in_ready_r <= 1'b0;
                  count_r    <= '0;
                  part_r     <= '0;
                  acc_r      <= dvd_mag_s;
                  dsr_r      <= dsr_mag_s;
`ifdef DIV_SIGNED_EN
                  neg_q_r    <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
                  neg_r_r    <= dividend[DIVIDEND_W-1];
`endif
                  if (divisor == '0) begin
                     quotient_r  <= '1;
                     remainder_r <= dividend[DIVISOR_W-1:0];
                     dbz_r       <= 1'b1;
                     out_valid_r <= 1'b1;
                     state_r     <= DONE;
                  end else begin
                     state_r <= RUN;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            RUN: begin
               acc_r  <= acc_next_s;
               part_r <= part_next_s;
               if (count_r == LAST_CNT) begin
                  count_r     <= '0;
                  quotient_r  <= q_final_s;
                  remainder_r <= r_final_s;
                  dbz_r       <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  count_r <= count_r + CW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end else begin
                  state_r <= DONE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_r;
   assign out_valid   = out_valid_r;
   assign quotient    = quotient_r;
   assign remainder   = remainder_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_restoring_divider_pl.sv
// Self-checking bench for restoring_divider_pl: arithmetic reference model plus hand-computed vectors.
// Build with DIV_SIGNED_EN defined to exercise the signed configuration.
module tb_restoring_divider_pl;
   localparam int DW = 16;
   localparam int SW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] dividend = '0;
   logic [SW-1:0] divisor = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] quotient;
   logic [SW-1:0] remainder;
   logic          div_by_zero;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [DW-1:0] q;
      logic [SW-1:0] r;
      logic          z;
   } exp_t;

   exp_t sb[$];

   restoring_divider_pl #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer division, truncation toward zero in signed mode.
   function automatic exp_t model(input logic [DW-1:0] a, input logic [SW-1:0] b);
      exp_t e;
      int sa, sd, qi, ri;
      sa = 0; sd = 0; qi = 0; ri = 0;
      if (b == 8'd0) begin
         e.q = 16'hFFFF;
         e.r = a[SW-1:0];
         e.z = 1'b1;
      end else begin
`ifdef DIV_SIGNED_EN
         sa = int'($signed(a));
         sd = int'($signed(b));
`else
         sa = int'({16'd0, a});
         sd = int'({24'd0, b});
`endif
         qi = sa / sd;
         ri = sa % sd;
         e.q = qi[DW-1:0];
         e.r = ri[SW-1:0];
         e.z = 1'b0;
      end
      return e;
   endfunction

   // Every cycle a result is presented it must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
         end else begin
            chk("model_quotient", {16'd0, quotient}, {16'd0, sb[0].q});
            chk("model_remainder", {24'd0, remainder}, {24'd0, sb[0].r});
            chk("model_div_by_zero", {31'd0, div_by_zero}, {31'd0, sb[0].z});
            if (out_ready) void'(sb.pop_front());
         end
      end
   end

   // Issue one operation; optionally pin the result to hand-computed literals and stall the consumer.
   task automatic run_op(input logic [DW-1:0] a, input logic [SW-1:0] b, input bit use_lit,
                         input logic [DW-1:0] lq, input logic [SW-1:0] lr, input int hold);
      int n;
      logic [DW-1:0] held_q;
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
      sb.push_back(model(a, b));
      @(posedge clk); #1;
      if (hold > 0) begin
         dividend = ~a;
         divisor  = b + 8'd3;
      end else begin
         in_valid = 1'b0;
      end
      // A divide-by-zero result is already presented by the accepting edge itself.
      n = 0;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("latency", n, (b == 8'd0) ? 32'd0 : 32'd16);
      if (use_lit) begin
         chk("lit_quotient", {16'd0, quotient}, {16'd0, lq});
         chk("lit_remainder", {24'd0, remainder}, {24'd0, lr});
         chk("lit_div_by_zero", {31'd0, div_by_zero}, (b == 8'd0) ? 32'd1 : 32'd0);
      end
      held_q = quotient;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_quotient", {16'd0, quotient}, {16'd0, held_q});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      out_ready = 1'b0;
      in_valid  = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_quotient", {16'd0, quotient}, 32'd0);
      chk("rst_remainder", {24'd0, remainder}, 32'd0);
      chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      run_op(16'h1234, 8'h34, 1'b1, 16'h0059, 8'h20, 0);
      run_op(16'h00FF, 8'h00, 1'b1, 16'hFFFF, 8'hFF, 0);
      run_op(16'hFFFF, 8'h01, 1'b1, 16'hFFFF, 8'h00, 0);
`ifdef DIV_SIGNED_EN
      run_op(16'hFFFF, 8'hFF, 1'b1, 16'h0001, 8'h00, 0);
      run_op(16'hFF9C, 8'h07, 1'b1, 16'hFFF2, 8'hFE, 0);
      run_op(16'h8000, 8'hFF, 1'b1, 16'h8000, 8'h00, 0);
      run_op(16'h0064, 8'hF9, 1'b1, 16'hFFF2, 8'h02, 0);
`else
      run_op(16'hFFFF, 8'hFF, 1'b1, 16'h0101, 8'h00, 0);
      run_op(16'h8000, 8'hFF, 1'b1, 16'h0080, 8'h80, 0);
`endif
      run_op(16'h0005, 8'h09, 1'b1, 16'h0000, 8'h05, 0);
      run_op(16'h0000, 8'h01, 1'b0, 16'h0000, 8'h00, 0);
      run_op(16'hABCD, 8'h80, 1'b0, 16'h0000, 8'h00, 0);
      run_op(16'h7FFF, 8'h7F, 1'b0, 16'h0000, 8'h00, 0);
      // Consumer stall with new operands offered, then the next op goes through.
      run_op(16'h1234, 8'h34, 1'b1, 16'h0059, 8'h20, 5);
      run_op(16'h00FF, 8'h00, 1'b1, 16'hFFFF, 8'hFF, 3);
      run_op(16'h4321, 8'h0D, 1'b0, 16'h0000, 8'h00, 0);

      // Reset while the divider is at RUN count 7.
      dividend = 16'h1234;
      divisor  = 8'h34;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("midrst_quotient", {16'd0, quotient}, 32'd0);
      chk("midrst_remainder", {24'd0, remainder}, 32'd0);
      chk("midrst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midrst_release_in_ready", {31'd0, in_ready}, 32'd1);
      run_op(16'h0064, 8'h07, 1'b1, 16'h000E, 8'h02, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
